// File: rtl/ks_ram_responder.sv
// Single-port word RAM that is first filled from a host image stream and then
// serves processor read/write requests, one access per request/ack handshake.
module ks_ram_responder #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              mem_ack,
  output logic              cpu_hold,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SERVE = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   load_cnt;
  logic [DATA_W-1:0]   mem [0:DEPTH-1];

  logic                mem_wr_en;
  logic [ADDR_W-1:0]   mem_wr_addr;
  logic [DATA_W-1:0]   mem_wr_data;

  // Image loading and processor writes share the one write port; reset
  // suppresses both so nothing presented alongside rst reaches the array.
  always_comb begin
    mem_wr_en   = 1'b0;
    mem_wr_addr = ram_addr;
    mem_wr_data = wr_data;
    if (!rst) begin
      if (state == LOAD && load_valid) begin
        mem_wr_en   = 1'b1;
        mem_wr_addr = load_cnt;
        mem_wr_data = load_data;
      end else if (state == SERVE && mem_req && mem_we) begin
        mem_wr_en   = 1'b1;
      end
    end
  end

  // Contents are never cleared; unloaded words keep whatever they held.
  always_ff @(posedge clk) begin
    if (mem_wr_en) begin
      mem[mem_wr_addr] <= mem_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOAD;
      load_cnt   <= '0;
      mem_ack    <= 1'b0;
      rd_data    <= '0;
      cpu_hold   <= 1'b1;
      load_done  <= 1'b0;
      load_ready <= 1'b1;
    end else begin
      mem_ack <= 1'b0;
      case (state)
        LOAD: begin
          if (load_valid) begin
            // The final address ends the load so the counter never wraps.
            if (load_last || load_cnt == LAST_ADDR) begin
              state      <= SERVE;
              cpu_hold   <= 1'b0;
              load_done  <= 1'b1;
              load_ready <= 1'b0;
            end else begin
              load_cnt <= load_cnt + 1'b1;
            end
          end
        end
        SERVE: begin
          if (mem_req) begin
            if (!mem_we) begin
              rd_data <= mem[ram_addr];
            end
            mem_ack <= 1'b1;
            state   <= ACK;
          end
        end
        ACK: begin
          // A still-held request is ignored here, giving one access per ack.
          state <= SERVE;
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

endmodule

// File: doc/ks_ram_responder.md
KS_RAM_RESPONDER -- requirements
Module: ks_ram_responder

Interface
REQ-001 Parameter ADDR_W, default 5, SHALL be the word-address width; depth is 2**ADDR_W words.
REQ-002 Parameter DATA_W, default 16, SHALL be the word width.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 mem_req  input  1  processor access request, held until mem_ack.
REQ-007 mem_we  input  1  1 = write, 0 = read; sampled with mem_req.
REQ-008 ram_addr  input  ADDR_W  processor word address.
REQ-009 wr_data  input  DATA_W  processor write data (processor data_out).
REQ-010 rd_data  output  DATA_W  read data to processor (processor data_in).
REQ-011 mem_ack  output  1  one-cycle pulse: access complete.
REQ-012 cpu_hold  output  1  high while the image is being loaded; processor must not start.
REQ-013 load_valid  input  1  host image word valid.
REQ-014 load_data  input  DATA_W  host image word.
REQ-015 load_last  input  1  marks the final image word; qualified by load_valid.
REQ-016 load_ready  output  1  block accepts the image word this cycle.
REQ-017 load_done  output  1  image load finished; stays high until reset.

Function
REQ-018 FSM states SHALL be LOAD, SERVE and ACK; LOAD is entered on reset.
REQ-019 In LOAD, load_ready SHALL be 1, and each cycle with load_valid=1 SHALL write load_data to mem[load_cnt] and increment load_cnt.
REQ-020 LOAD SHALL exit to SERVE on the accepting cycle where load_last=1 or load_cnt = 2**ADDR_W-1. load_cnt SHALL never wrap. A word offered after the exit is not accepted.
REQ-021 Words not written during LOAD SHALL retain their prior contents; the block does not clear memory.
REQ-022 In LOAD, mem_req SHALL be ignored: no ack and no memory access.
REQ-023 In SERVE with mem_req=1, the block SHALL perform the access on that edge and move to ACK.
  - mem_we=1: mem[ram_addr] <= wr_data.
  - mem_we=0: rd_data <= mem[ram_addr].
REQ-024 In ACK, mem_ack SHALL be 1 for exactly one cycle. rd_data SHALL be valid in that cycle. The state SHALL then return to SERVE.
REQ-025 In ACK, mem_req SHALL be ignored, so a held request is serviced at most once per ack. Peak throughput is one access per two cycles.
REQ-026 Read latency SHALL be: request cycle N, data and ack in cycle N+1.
REQ-027 rd_data SHALL hold its last value outside ACK and SHALL be unchanged by writes.
REQ-028 A read issued immediately after a write to the same address SHALL return the newly written value.
REQ-029 cpu_hold SHALL equal 1 in LOAD and 0 otherwise. load_done SHALL equal the complement of cpu_hold.
REQ-030 load_ready SHALL be 0 in SERVE and ACK.
REQ-031 Out-of-range addresses cannot occur: ram_addr is exactly ADDR_W bits, and every value is a valid word.

Reset
REQ-032 With rst=1 on a rising edge, the block SHALL:
  - enter LOAD;
  - set load_cnt=0, mem_ack=0, rd_data=0;
  - drive cpu_hold=1, load_done=0, load_ready=1 from the next cycle.
REQ-033 Reset SHALL take priority over every other input on the same edge. A write or load word presented during rst=1 SHALL NOT update memory.
REQ-034 A reset during ACK or mid-LOAD SHALL abort the access or load, and the next load SHALL restart at address 0.

Verification
REQ-035 Full load: 32 consecutive words 0x1000+i with load_valid=1 and no load_last -> load_ready drops after word 31, load_done=1, cpu_hold=0, and reading address 7 returns 0x1007.
REQ-036 Short load: 3 words 0xAAAA, 0xBBBB, 0xCCCC with load_last on the third -> SERVE entered; addresses 0 to 2 read back; a 4th word offered is not accepted.
REQ-037 Read timing: in SERVE, mem_req=1, mem_we=0, ram_addr=5 in cycle N -> mem_ack=1 and rd_data=mem[5] in cycle N+1 only; mem_req held through N+1 gives no second ack in N+1.
REQ-038 Write-then-read: write 0x1234 to address 31, then read address 31 -> rd_data=0x1234, and rd_data is unchanged during the write's ack cycle.
REQ-039 Request during load: mem_req=1 while cpu_hold=1 -> no mem_ack and no memory change until load completes.
REQ-040 Mid-load reset: rst pulsed after 10 loaded words -> cpu_hold=1, load_cnt restarts at 0, and the next load word is written to address 0.
